// File: rtl/ascon_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : ascon_serial_loader
// Function : Captures a parallel ASCON job and streams it MSB-first to a
//            serial ASCON core, strobes start, then waits for completion.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_serial_loader #(
  parameter int k         = 128,
  parameter int A_l       = 40,
  parameter int text_l    = 40,
  parameter int START_LEN = 5,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [k-1:0]      key_in,
  input  logic [127:0]      nonce_in,
  input  logic [A_l-1:0]    ad_in,
  input  logic [text_l-1:0] pt_in,
  input  logic              mode_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              key_SI,
  output logic              nonce_SI,
  output logic              associated_SI,
  output logic              plaintext_SI,
  output logic              encryption_s_SI,
  output logic              decryption_s_SI,
  input  logic              encryption_r_SO,
  input  logic              decryption_r_SO,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int c_MAX     = (k > A_l) ? ((k > text_l) ? k : text_l)
                                       : ((A_l > text_l) ? A_l : text_l);
  localparam int c_CNT_TOP = (c_MAX > START_LEN)
                             ? ((c_MAX > TIMEOUT) ? c_MAX : TIMEOUT)
                             : ((START_LEN > TIMEOUT) ? START_LEN : TIMEOUT);
  localparam int c_CNT_W   = $clog2(c_CNT_TOP + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [k-1:0]         r_key;
  logic [127:0]         r_nonce;
  logic [A_l-1:0]       r_ad;
  logic [text_l-1:0]    r_pt;
  logic                 r_mode;

  // Fields are shifted left in place; the next frame bit is always the MSB
  // of the shifted value, and zeros fill in once a short field runs out.
  logic [k-1:0]         w_key_sh;
  logic [127:0]         w_nonce_sh;
  logic [A_l-1:0]       w_ad_sh;
  logic [text_l-1:0]    w_pt_sh;
  logic                 w_flag;

  assign w_key_sh   = r_key << 1;
  assign w_nonce_sh = r_nonce << 1;
  assign w_ad_sh    = r_ad << 1;
  assign w_pt_sh    = r_pt << 1;
  assign w_flag     = r_mode ? decryption_r_SO : encryption_r_SO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_key           <= '0;
      r_nonce         <= '0;
      r_ad            <= '0;
      r_pt            <= '0;
      r_mode          <= 1'b0;
      load_ready      <= 1'b1;
      key_SI          <= 1'b0;
      nonce_SI        <= 1'b0;
      associated_SI   <= 1'b0;
      plaintext_SI    <= 1'b0;
      encryption_s_SI <= 1'b0;
      decryption_s_SI <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            r_key         <= key_in;
            r_nonce       <= nonce_in;
            r_ad          <= ad_in;
            r_pt          <= pt_in;
            r_mode        <= mode_in;
            r_cnt         <= '0;
            timeout_err   <= 1'b0;
            // Frame bit 0 goes out together with the capture.
            key_SI        <= key_in[k-1];
            nonce_SI      <= nonce_in[127];
            associated_SI <= ad_in[A_l-1];
            plaintext_SI  <= pt_in[text_l-1];
            load_ready    <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt == c_CNT_W'(c_MAX - 1)) begin
            key_SI          <= 1'b0;
            nonce_SI        <= 1'b0;
            associated_SI   <= 1'b0;
            plaintext_SI    <= 1'b0;
            encryption_s_SI <= ~r_mode;
            decryption_s_SI <= r_mode;
            r_cnt           <= '0;
            r_state         <= S_START;
          end else begin
            r_key         <= w_key_sh;
            r_nonce       <= w_nonce_sh;
            r_ad          <= w_ad_sh;
            r_pt          <= w_pt_sh;
            key_SI        <= w_key_sh[k-1];
            nonce_SI      <= w_nonce_sh[127];
            associated_SI <= w_ad_sh[A_l-1];
            plaintext_SI  <= w_pt_sh[text_l-1];
            r_cnt         <= r_cnt + c_CNT_W'(1);
          end
        end
        S_START: begin
          if (r_cnt == c_CNT_W'(START_LEN - 1)) begin
            encryption_s_SI <= 1'b0;
            decryption_s_SI <= 1'b0;
            r_cnt           <= '0;
            r_state         <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (w_flag) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_serial_loader
// Function : Directed self-checking bench for ascon_serial_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_serial_loader;

  localparam int c_TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic [127:0] nonce_in;
  logic [39:0]  ad_in;
  logic [39:0]  pt_in;
  logic         mode_in;
  logic         load_valid;
  logic         load_ready;
  logic         key_SI, nonce_SI, associated_SI, plaintext_SI;
  logic         encryption_s_SI, decryption_s_SI;
  logic         encryption_r_SO, decryption_r_SO;
  logic         busy, done, timeout_err;
  logic [9:0]   w_outs;

  always #5 clk = ~clk;

  assign w_outs = {key_SI, nonce_SI, associated_SI, plaintext_SI, encryption_s_SI,
                   decryption_s_SI, busy, done, timeout_err, load_ready};

  ascon_serial_loader #(.TIMEOUT(c_TO)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in),
    .pt_in(pt_in), .mode_in(mode_in), .load_valid(load_valid), .load_ready(load_ready),
    .key_SI(key_SI), .nonce_SI(nonce_SI), .associated_SI(associated_SI),
    .plaintext_SI(plaintext_SI), .encryption_s_SI(encryption_s_SI),
    .decryption_s_SI(decryption_s_SI), .encryption_r_SO(encryption_r_SO),
    .decryption_r_SO(decryption_r_SO), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  localparam logic [127:0] c_K  = 128'h00a14b66b34c7101e798a43505a17d58;
  localparam logic [127:0] c_N  = 128'h33b1ba07991290964c7d834e82a9e9b7;
  localparam logic [39:0]  c_AD = 40'h4153434f4e;
  localparam logic [39:0]  c_PT = 40'h6173636f6e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Presents a job for one capture edge, then scrambles the inputs.
  task automatic load(input logic [127:0] kk, input logic [127:0] nn,
                      input logic [39:0] aa, input logic [39:0] pp, input logic m);
    key_in = kk; nonce_in = nn; ad_in = aa; pt_in = pp; mode_in = m;
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    key_in = ~kk; nonce_in = ~nn; ad_in = ~aa; pt_in = ~pp; mode_in = ~m;
  endtask

  task automatic collect(output logic [127:0] kr, output logic [127:0] nr,
                         output logic [127:0] ar, output logic [127:0] pr, output int bad);
    bad = 0;
    for (int n = 0; n < 128; n++) begin
      kr[127-n] = key_SI;
      nr[127-n] = nonce_SI;
      ar[127-n] = associated_SI;
      pr[127-n] = plaintext_SI;
      if (!busy || load_ready || encryption_s_SI || decryption_s_SI || done) bad++;
      if (n == 5) load_valid = 1'b1;
      if (n == 6) load_valid = 1'b0;
      step;
    end
  endtask

  task automatic strobe(output int ne, output int nd);
    ne = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      ne += int'(encryption_s_SI);
      nd += int'(decryption_s_SI);
      step;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kr, nr, ar, pr;
    int bad, ne, nd, t_done, t_ready, t_busy2, done_cnt;
    bit found;

    rst = 1'b1; load_valid = 1'b0; mode_in = 1'b0;
    key_in = '0; nonce_in = '0; ad_in = '0; pt_in = '0;
    encryption_r_SO = 1'b0; decryption_r_SO = 1'b0;
    repeat (2) step;
    check("reset_outs", w_outs, 10'b0000000001);
    rst = 1'b0;
    step;
    check("idle_outs", w_outs, 10'b0000000001);

    // Encrypt with the reference vector; completion one cycle into WAIT.
    load(c_K, c_N, c_AD, c_PT, 1'b0);
    collect(kr, nr, ar, pr, bad);
    check("enc_key_frame", kr, c_K);
    check("enc_nonce_frame", nr, c_N);
    check("enc_ad_frame", ar, {c_AD, 88'h0});
    check("enc_pt_frame", pr, {c_PT, 88'h0});
    check("enc_key_bits0_7", kr[127:120], 8'h00);
    check("enc_ad_bits0_7", ar[127:120], 8'b01000001);
    check("enc_pt_bits0_7", pr[127:120], 8'b01100001);
    check("enc_shift_flags", bad, 0);
    strobe(ne, nd);
    check("enc_strobe_len", ne, 5);
    check("enc_no_dec_strobe", nd, 0);
    check("enc_wait_outs", w_outs, 10'b0000001000);
    encryption_r_SO = 1'b1;
    step;
    check("enc_done", done, 1'b1);
    encryption_r_SO = 1'b0;
    step;
    check("enc_back_idle", w_outs, 10'b0000000001);

    // Decrypt; other flag toggles, own flag raised 10 cycles into WAIT.
    load(c_N, c_K, c_PT, c_AD, 1'b1);
    collect(kr, nr, ar, pr, bad);
    check("dec_key_frame", kr, c_N);
    check("dec_pt_frame", pr, {c_AD, 88'h0});
    check("dec_shift_flags", bad, 0);
    strobe(ne, nd);
    check("dec_no_enc_strobe", ne, 0);
    check("dec_strobe_len", nd, 5);
    bad = 0;
    for (int w = 0; w < 10; w++) begin
      encryption_r_SO = w[0];
      if (done || !busy || encryption_s_SI || decryption_s_SI) bad++;
      step;
    end
    check("dec_wait_ignores_enc", bad, 0);
    decryption_r_SO = 1'b1;
    encryption_r_SO = 1'b0;
    step;
    check("dec_done", done, 1'b1);
    decryption_r_SO = 1'b0;
    step;
    check("dec_back_idle", w_outs, 10'b0000000001);

    // Timeout: no flag at all.
    load(c_K, c_N, c_AD, c_PT, 1'b0);
    collect(kr, nr, ar, pr, bad);
    strobe(ne, nd);
    bad = 0;
    for (int w = 0; w < c_TO; w++) begin
      if (done || timeout_err) bad++;
      step;
    end
    check("to_wait_quiet", bad, 0);
    check("to_done_err", {done, timeout_err}, 2'b11);
    step;
    check("to_sticky_idle", w_outs, 10'b0000000011);

    // Reset mid-shift at bit 60, then a fresh load from bit 0.
    load(c_N, c_K, c_PT, c_AD, 1'b0);
    check("to_cleared_on_load", timeout_err, 1'b0);
    for (int n = 0; n < 60; n++) step;
    rst = 1'b1;
    #1;
    check("rst_async_outs", w_outs, 10'b0000000001);
    step;
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 140; n++) begin
      if (w_outs !== 10'b0000000001) bad++;
      step;
    end
    check("rst_no_strobe", bad, 0);
    load(128'h0123456789abcdef_fedcba9876543210, c_N, 40'h80_0000_0001, 40'hff00ff00ff, 1'b0);
    collect(kr, nr, ar, pr, bad);
    check("rst_reload_key", kr, 128'h0123456789abcdef_fedcba9876543210);
    check("rst_reload_ad", ar, {40'h80_0000_0001, 88'h0});
    check("rst_reload_pt", pr, {40'hff00ff00ff, 88'h0});
    strobe(ne, nd);
    check("rst_reload_strobe", ne, 5);
    encryption_r_SO = 1'b1;
    step;
    check("rst_reload_done", done, 1'b1);
    encryption_r_SO = 1'b0;
    step;

    // load_valid held high; completion flag already high on WAIT entry.
    key_in = c_K; nonce_in = c_N; ad_in = c_AD; pt_in = c_PT; mode_in = 1'b0;
    load_valid = 1'b1;
    encryption_r_SO = 1'b1;
    t_done = -1; t_ready = -1; t_busy2 = -1; done_cnt = 0;
    for (int t = 1; t <= 140; t++) begin
      step;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = t;
      end
      if (load_ready && t_ready < 0) t_ready = t;
      if (t_ready > 0 && t > t_ready && busy && t_busy2 < 0) t_busy2 = t;
    end
    load_valid = 1'b0;
    check("hold_done_cycle", t_done, 135);
    check("hold_done_once", done_cnt, 1);
    check("hold_ready_cycle", t_ready, 136);
    check("hold_second_capture", t_busy2, 137);
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      step;
      if (done) found = 1'b1;
    end
    check("hold_second_done", found, 1'b1);
    encryption_r_SO = 1'b0;
    step;
    check("hold_final_idle", w_outs, 10'b0000000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_serial_loader.md
ASCON_SERIAL_LOADER -- requirements
Module: ascon_serial_loader

Interface
REQ-001 Parameters: k default 128, key width; A_l default 40, associated-data width; text_l default 40, plaintext/ciphertext width; START_LEN default 5, start-strobe length in cycles; TIMEOUT default 4096, maximum wait cycles for core completion.
REQ-002 Derived constant MAX SHALL be max(k, A_l, text_l), the serial frame length in cycles (128 at defaults).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 key_in  in  k  parallel key; nonce_in  in  128  nonce; ad_in  in  A_l  associated data; pt_in  in  text_l  plaintext or ciphertext.
REQ-006 mode_in  in  1  0 = encrypt, 1 = decrypt; sampled with the load.
REQ-007 load_valid  in  1  request to load; load_ready  out  1  high only in IDLE.
REQ-008 key_SI, nonce_SI, associated_SI, plaintext_SI  out  1 each  serial bits to the ASCON core, MSB first.
REQ-009 encryption_s_SI, decryption_s_SI  out  1 each  start strobes to the core.
REQ-010 encryption_r_SO, decryption_r_SO  in  1 each  completion flags from the core.
REQ-011 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse; timeout_err  out  1  sticky error flag.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, START, WAIT, DONE.
REQ-013 IDLE: on a rising edge with load_valid=1, capture all data inputs and mode_in into internal registers, clear the bit counter, and go to SHIFT; otherwise stay.
REQ-014 SHIFT: each cycle the serial outputs SHALL present frame bit n, n = 0..MAX-1, with n = 0 in the first SHIFT cycle.
REQ-015 Bit n of a field of width L SHALL be field[L-1-n] for n < L and 0 for n >= L; nonce uses L = 128.
REQ-016 All serial outputs and strobes SHALL be registered; no combinational path from inputs to outputs.
REQ-017 After exactly MAX SHIFT cycles, go to START; serial outputs are 0 outside SHIFT.
REQ-018 START: hold encryption_s_SI=1 (mode 0) or decryption_s_SI=1 (mode 1) for exactly START_LEN cycles; the other strobe stays 0; then go to WAIT.
REQ-019 WAIT: go to DONE on the first cycle the completion flag for the captured mode is 1; ignore the other flag.
REQ-020 WAIT: count cycles; on reaching TIMEOUT with no completion, set timeout_err=1 and go to DONE.
REQ-021 DONE: done=1 for one cycle, then go to IDLE; timeout_err clears only on reset or on the next accepted load.
REQ-022 load_valid outside IDLE SHALL be ignored; inputs changing after capture SHALL NOT affect the frame.
REQ-023 A completion flag already high on WAIT entry SHALL complete WAIT on its first cycle.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and drive all outputs to 0 except load_ready=1; counters, captured registers and timeout_err clear.
REQ-025 rst asserted mid-SHIFT, mid-START or mid-WAIT SHALL abort with no further strobe; after release the block is in IDLE with load_ready=1.

Verification
REQ-026 Load with key 00a14b66b34c7101e798a43505a17d58, nonce 33b1ba07991290964c7d834e82a9e9b7, AD 4153434f4e, PT 6173636f6e, mode 0 -> 128 SHIFT cycles; key_SI bits 0-7 = 0; associated_SI bits 0-7 = 01000001; plaintext_SI bits 0-7 = 01100001; AD/PT bits 40-127 = 0; then encryption_s_SI high for 5 cycles.
REQ-027 Mode 1 load, decryption_r_SO raised 10 cycles into WAIT -> only decryption_s_SI pulses (5 cycles); done pulses exactly one cycle after the flag is seen; encryption_r_SO toggling during WAIT has no effect.
REQ-028 Flag never raised, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, done pulse, IDLE; next load clears timeout_err.
REQ-029 rst pulsed at SHIFT bit 60 -> all outputs 0, load_ready=1 asynchronously; no start strobe follows; a new load restarts from bit 0.
REQ-030 load_valid held high continuously across two operations -> second capture only in IDLE after done; the loads are 1+128+5+WAIT+1 cycles apart, and load_ready is low throughout the first.
